// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle main controller and the shared datapath.
// The controller side (master) reads IR fields and status and drives every
// datapath enable/select; the datapath side (slave) is the mirror image.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       aluZero;
  logic       memReady;

  logic       pcWrite;
  logic       irWrite;
  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic       iorD;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       immExtendMode;
  logic [1:0] regDst;
  logic [1:0] memToReg;
  logic [1:0] pcSrc;
  logic       instRetired;
  logic       illegalOp;
  logic [3:0] stateOut;

  modport master (
    input  opcode, func, aluZero, memReady,
    output pcWrite, irWrite, regWrite, memRead, memWrite, iorD, aluSrcA,
           aluSrcB, aluOp, immExtendMode, regDst, memToReg, pcSrc,
           instRetired, illegalOp, stateOut
  );

  modport slave (
    output opcode, func, aluZero, memReady,
    input  pcWrite, irWrite, regWrite, memRead, memWrite, iorD, aluSrcA,
           aluSrcB, aluOp, immExtendMode, regDst, memToReg, pcSrc,
           instRetired, illegalOp, stateOut
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller. Sequences one ALU and one unified memory
// port over several cycles per instruction. Outputs are decoded from the
// state register (so an asynchronous reset clears them at once), with a few
// Mealy terms on memReady, aluZero and the IR fields where the handshake or
// branch condition must act in the same cycle.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  mc_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEX   = 4'd7,
    S_RTWB   = 4'd8,
    S_BRANCH = 4'd9,
    S_ITEX   = 4'd10,
    S_ITWB   = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13,
    S_JR     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state_q, state_d;

  logic       pc_write, ir_write, reg_write, mem_read, mem_write, ior_d;
  logic       alu_src_a, imm_extend_mode, inst_retired, illegal_op;
  logic [1:0] alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src;

  // andi/ori/xori/lui (0011xx) take a zero-extended immediate
  logic zext_imm;
  assign zext_imm = (bus.opcode[5:2] == 4'b0011);

  // Next-state selection, including the DECODE dispatch on opcode/func
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:        state_d = (bus.func == FN_JR) ? S_JR : S_RTEX;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI: state_d = S_ITEX;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.memReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.memReady ? S_FETCH : S_MEMWR;
      S_RTEX:   state_d = S_RTWB;
      S_ITEX:   state_d = S_ITWB;
      S_MEMWB, S_RTWB, S_BRANCH, S_ITWB,
      S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath control decode from the current state (plus Mealy terms)
  always_comb begin
    pc_write        = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ior_d           = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    imm_extend_mode = 1'b1;
    reg_dst         = 2'b00;
    mem_to_reg      = 2'b00;
    pc_src          = 2'b00;
    inst_retired    = 1'b0;
    illegal_op      = 1'b0;
    case (state_q)
      S_IDLE: imm_extend_mode = 1'b0;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.memReady;
        pc_write  = bus.memReady;
      end
      S_DECODE: begin
        // PC + (imm << 2) lands in ALUOut for a possible branch
        alu_src_b = 2'b11;
        if (state_d == S_FETCH) illegal_op = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
      end
      S_MEMWB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 2'b01;
        inst_retired = 1'b1;
      end
      S_MEMWR: begin
        mem_write    = 1'b1;
        ior_d        = 1'b1;
        inst_retired = bus.memReady;
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTWB: begin
        reg_write    = 1'b1;
        reg_dst      = 2'b01;
        inst_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b01;
        pc_src       = 2'b01;
        pc_write     = (bus.opcode == OP_BNE) ? ~bus.aluZero : bus.aluZero;
        inst_retired = 1'b1;
      end
      S_ITEX: begin
        alu_src_a       = 1'b1;
        alu_src_b       = 2'b10;
        alu_op          = 2'b11;
        imm_extend_mode = ~zext_imm;
      end
      S_ITWB: begin
        reg_write       = 1'b1;
        imm_extend_mode = ~zext_imm;
        inst_retired    = 1'b1;
      end
      S_JUMP: begin
        pc_write     = 1'b1;
        pc_src       = 2'b10;
        inst_retired = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4, which is the link value
        pc_write     = 1'b1;
        pc_src       = 2'b10;
        reg_write    = 1'b1;
        reg_dst      = 2'b10;
        mem_to_reg   = 2'b10;
        inst_retired = 1'b1;
      end
      S_JR: begin
        pc_write     = 1'b1;
        pc_src       = 2'b11;
        inst_retired = 1'b1;
      end
      default: imm_extend_mode = 1'b0;
    endcase
  end

  // State register; reset drops to IDLE immediately, abandoning any access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign bus.pcWrite       = pc_write;
  assign bus.irWrite       = ir_write;
  assign bus.regWrite      = reg_write;
  assign bus.memRead       = mem_read;
  assign bus.memWrite      = mem_write;
  assign bus.iorD          = ior_d;
  assign bus.aluSrcA       = alu_src_a;
  assign bus.aluSrcB       = alu_src_b;
  assign bus.aluOp         = alu_op;
  assign bus.immExtendMode = imm_extend_mode;
  assign bus.regDst        = reg_dst;
  assign bus.memToReg      = mem_to_reg;
  assign bus.pcSrc         = pc_src;
  assign bus.instRetired   = inst_retired;
  assign bus.illegalOp     = illegal_op;
  assign bus.stateOut      = state_q;

endmodule
